hazard_ctrl: RTL
================

# hazard_ctrl

Pipeline hazard and stall controller for the five-stage RV32I core. It produces the forwarding mux selects and the per-register load/reset strobes of the shared `control` struct (`control_itf`). It freezes the pipeline across I-cache and D-cache misses, buffering whichever response arrives first. It also detects load-use hazards and squashes IF/ID and ID/EX on EX-stage redirects.

## Interface
- `PERF_W`, default 32: width of the performance counters.
- `clk`  in  1  core clock.
- `rst_n`  in  1  one clock; reset is asynchronous and active-low.
- `ifid_rs1`, `ifid_rs2`  in  5 each  source registers of the instruction in ID.
- `ifid_uses_rs2`  in  1  the ID instruction reads rs2 (R/S/B formats).
- `idex_rs1`, `idex_rs2`, `idex_rd`  in  5 each  register fields of the instruction in EX.
- `idex_load`  in  1  the EX instruction is a load (`dcache_read` of its ctrl_word).
- `exmem_rd`  in  5  destination register of the instruction in MEM.
- `exmem_load_regfile`  in  1  the MEM instruction writes the regfile.
- `exmem_load`  in  1  the MEM instruction is a load.
- `memwb_rd`  in  5  destination register of the instruction in WB.
- `memwb_load_regfile`  in  1  the WB instruction writes the regfile.
- `ex_redirect`  in  1  the EX stage resolved a taken branch or jump.
- `imem_resp`  in  1  I-cache single-cycle response pulse.
- `imem_rdata`  in  32  I-cache data.
- `dmem_req`  in  1  the MEM stage holds a load or store.
- `dmem_resp`  in  1  D-cache response pulse.
- `dmem_rdata`  in  32  D-cache data.
- `imem_read`  out  1  I-cache request, gated.
- `dmem_req_gated`  out  1  D-cache request, gated.
- `instr_out`  out  32  instruction presented to IF/ID.
- `mem_rdata_out`  out  32  load data presented to MEM/WB.
- `pc_load`  out  1  PC register load enable.
- `ctl`  out  `control_itf::control`  mux selects and pipe load/reset strobes.
- `stall_cycles`, `flush_count`  out  `PERF_W` each  performance counters.

## Operation
- Registered state:
  - `i_done`/`ibuf`: an I-response was captured while the pipeline could not advance.
  - `d_done`/`dbuf`: the same for D-responses.
  - Two counters.
- Per-cycle terms:
  - `i_ok = imem_resp | i_done`
  - `d_ok = ~dmem_req | dmem_resp | d_done`
  - `advance = i_ok & d_ok`
- `instr_out` = `i_done ? ibuf : imem_rdata`. `mem_rdata_out` = `d_done ? dbuf : dmem_rdata`.
- `imem_read = ~i_done`. `dmem_req_gated = dmem_req & ~d_done`.
- Buffer flags:
  - When `~advance` and `imem_resp`: set `i_done` and capture `ibuf`.
  - When `~advance` and `dmem_resp`: set `d_done` and capture `dbuf`.
  - When `advance`: clear both flags.
- Load-use hazard:
  - `lu = idex_load & idex_rd!=0 & (idex_rd==ifid_rs1 | ifid_uses_rs2 & idex_rd==ifid_rs2)`.
- Strobes when `~advance`:
  - All `pipe_load_*` = 0, `pc_load` = 0, all `pipe_rst_*` = 0.
- Strobes when `advance` and `ex_redirect`. Redirect takes priority over `lu`:
  - `pc_load` = 1.
  - `pipe_load_*` all 1.
  - `pipe_rst_ifid` = 1, `pipe_rst_idex` = 1.
- Strobes when `advance` and `lu`:
  - `pc_load` = 0, `pipe_load_ifid` = 0.
  - `pipe_rst_idex` = 1 (bubble).
  - `pipe_load_exmem` = 1, `pipe_load_memwb` = 1.
  - The instruction is refetched, because the PC is held.
- Strobes when `advance` otherwise:
  - `pc_load` = 1 and all `pipe_load_*` = 1.
  - `pipe_rst_*` = 0.
- Forwarding, applied to `rs1mux_sel` from `idex_rs1` and to `rs2mux_sel` from `idex_rs2`:
  - 2'b01 (EX/MEM ALU result) if `exmem_load_regfile & ~exmem_load & exmem_rd!=0 & exmem_rd==rsX`.
  - Else 2'b10 (MEM/WB writeback) if `memwb_load_regfile & memwb_rd!=0 & memwb_rd==rsX`.
  - Else 2'b00 (regfile).
  - EX/MEM has priority. Register x0 never forwards.
  - Forwarding is independent of stalls.
- Counters:
  - `stall_cycles` increments on every cycle with `~advance | lu`.
  - `flush_count` increments on every cycle with `advance & ex_redirect`.
  - Both wrap modulo 2^`PERF_W`.

## Timing
- All strobes, selects and gated requests are combinational from inputs and state, with zero latency.
- Buffer flags and counters update on the rising edge of `clk`.
- Reset (`rst_n` low, asynchronous):
  - `i_done`, `d_done`, `ibuf`, `dbuf` and both counters = 0.
  - `pc_load` and all `pipe_load_*` forced to 0; all `pipe_rst_*` forced to 1.
  - `imem_read` = 0 and `dmem_req_gated` = 0.
  - Normal operation resumes on the first edge after deassertion.
- A flag set in cycle N means the request is dropped from cycle N+1. The cache must see the request deasserted after its response.
- Both responses in the same cycle: advance immediately, no buffering.
- A response arriving in the same cycle as the buffered one completes the set: advance, and clear flags at the edge.
- Reset asserted mid-miss: the buffers are discarded and the caches see their requests deasserted.

## Structure
- `control_itf` package: the `control` struct (already present), plus the constants `FWD_REGFILE` (2'b00), `FWD_EXMEM` (2'b01) and `FWD_MEMWB` (2'b10).
- One sub-module, `resp_buffer`, instantiated twice, once for I and once for D. It holds the 32-bit data, the done flag, and the select/gate logic.

## Test plan
- Load to x5 in EX, `add x6,x5,x7` in ID, both caches hit → exactly one cycle with `pipe_load_ifid`=0, `pipe_rst_idex`=1, `pc_load`=0; `stall_cycles`=1.
- EX/MEM writes x3 (ALU), MEM/WB writes x3, `idex_rs1`=3 → `rs1mux_sel`=01; same with `idex_rd`/`rs1`=0 → 00.
- `imem_resp` in cycle 2 (data 0x00A00093), `dmem_resp` in cycle 5 → `i_done` high in cycles 3–5, `imem_read`=0 in cycles 3–5, advance in cycle 5 with `instr_out`=0x00A00093.
- `ex_redirect` with both hits → `pc_load`=1, `pipe_rst_ifid`=`pipe_rst_idex`=1; `flush_count`=1. Redirect coincident with `lu` → redirect behaviour only.
- `ex_redirect` during D-miss → no reset strobes until the `dmem_resp` cycle, then the flush.
- `rst_n` low during a buffered I-miss → `i_done`=0 immediately, `pipe_rst_*`=1, counters 0.

Source files
------------

// File: rtl/control_itf.sv
// Shared pipeline control bundle and forwarding constants for the five-stage RV32I core.
package control_itf;

  localparam logic [1:0] FWD_REGFILE = 2'b00;
  localparam logic [1:0] FWD_EXMEM   = 2'b01;
  localparam logic [1:0] FWD_MEMWB   = 2'b10;

  typedef struct packed {
    logic [1:0] rs1mux_sel;
    logic [1:0] rs2mux_sel;
    logic       pipe_load_ifid;
    logic       pipe_load_idex;
    logic       pipe_load_exmem;
    logic       pipe_load_memwb;
    logic       pipe_rst_ifid;
    logic       pipe_rst_idex;
    logic       pipe_rst_exmem;
    logic       pipe_rst_memwb;
  } control;

  // EX/MEM wins over MEM/WB; a load in EX/MEM has no data yet, and x0 is never forwarded.
  function automatic logic [1:0] fwd_sel(
    input logic [4:0] rs,
    input logic [4:0] exmem_rd,
    input logic       exmem_wr,
    input logic       exmem_ld,
    input logic [4:0] memwb_rd,
    input logic       memwb_wr
  );
    logic [1:0] sel;
    sel = FWD_REGFILE;
    if (exmem_wr && !exmem_ld && exmem_rd != 5'd0 && exmem_rd == rs)
      sel = FWD_EXMEM;
    else if (memwb_wr && memwb_rd != 5'd0 && memwb_rd == rs)
      sel = FWD_MEMWB;
    return sel;
  endfunction

endpackage

// File: rtl/resp_buffer.sv
// Holds a cache response that arrived while the pipeline was frozen, and drops the
// request from the next cycle so the cache sees it deasserted after responding.
module resp_buffer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        advance,
  input  logic        req,
  input  logic        resp,
  input  logic [31:0] rdata,
  output logic        ok,
  output logic        req_gated,
  output logic [31:0] data
);

  logic        done;
  logic [31:0] data_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done   <= 1'b0;
      data_q <= 32'd0;
    end else if (advance) begin
      done <= 1'b0;
    end else if (resp) begin
      done   <= 1'b1;
      data_q <= rdata;
    end
  end

  assign ok        = ~req | resp | done;
  assign req_gated = rst_n & req & ~done;
  assign data      = done ? data_q : rdata;

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard/stall controller: forwarding selects, pipe load/reset strobes, cache-miss freeze
// with response buffering, load-use bubbles and redirect flushes. Strobes are combinational.
module hazard_ctrl
  import control_itf::*;
#(
  parameter int PERF_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [4:0]        ifid_rs1,
  input  logic [4:0]        ifid_rs2,
  input  logic              ifid_uses_rs2,
  input  logic [4:0]        idex_rs1,
  input  logic [4:0]        idex_rs2,
  input  logic [4:0]        idex_rd,
  input  logic              idex_load,
  input  logic [4:0]        exmem_rd,
  input  logic              exmem_load_regfile,
  input  logic              exmem_load,
  input  logic [4:0]        memwb_rd,
  input  logic              memwb_load_regfile,
  input  logic              ex_redirect,
  input  logic              imem_resp,
  input  logic [31:0]       imem_rdata,
  input  logic              dmem_req,
  input  logic              dmem_resp,
  input  logic [31:0]       dmem_rdata,
  output logic              imem_read,
  output logic              dmem_req_gated,
  output logic [31:0]       instr_out,
  output logic [31:0]       mem_rdata_out,
  output logic              pc_load,
  output control            ctl,
  output logic [PERF_W-1:0] stall_cycles,
  output logic [PERF_W-1:0] flush_count
);

  logic i_ok;
  logic d_ok;
  logic advance;
  logic lu;

  // The I-side always has a fetch outstanding, so its request is tied high.
  resp_buffer u_ibuf (
    .clk       (clk),
    .rst_n     (rst_n),
    .advance   (advance),
    .req       (1'b1),
    .resp      (imem_resp),
    .rdata     (imem_rdata),
    .ok        (i_ok),
    .req_gated (imem_read),
    .data      (instr_out)
  );

  resp_buffer u_dbuf (
    .clk       (clk),
    .rst_n     (rst_n),
    .advance   (advance),
    .req       (dmem_req),
    .resp      (dmem_resp),
    .rdata     (dmem_rdata),
    .ok        (d_ok),
    .req_gated (dmem_req_gated),
    .data      (mem_rdata_out)
  );

  assign advance = i_ok & d_ok;

  assign lu = idex_load & (idex_rd != 5'd0) &
              ((idex_rd == ifid_rs1) | (ifid_uses_rs2 & (idex_rd == ifid_rs2)));

  always_comb begin
    ctl            = '0;
    pc_load        = 1'b0;
    ctl.rs1mux_sel = fwd_sel(idex_rs1, exmem_rd, exmem_load_regfile, exmem_load,
                             memwb_rd, memwb_load_regfile);
    ctl.rs2mux_sel = fwd_sel(idex_rs2, exmem_rd, exmem_load_regfile, exmem_load,
                             memwb_rd, memwb_load_regfile);
    if (!rst_n) begin
      ctl.pipe_rst_ifid  = 1'b1;
      ctl.pipe_rst_idex  = 1'b1;
      ctl.pipe_rst_exmem = 1'b1;
      ctl.pipe_rst_memwb = 1'b1;
    end else if (advance) begin
      ctl.pipe_load_idex  = 1'b1;
      ctl.pipe_load_exmem = 1'b1;
      ctl.pipe_load_memwb = 1'b1;
      if (ex_redirect) begin
        // The redirect squashes the load consumer anyway, so it outranks the bubble.
        pc_load            = 1'b1;
        ctl.pipe_load_ifid = 1'b1;
        ctl.pipe_rst_ifid  = 1'b1;
        ctl.pipe_rst_idex  = 1'b1;
      end else if (lu) begin
        ctl.pipe_rst_idex = 1'b1;
      end else begin
        pc_load            = 1'b1;
        ctl.pipe_load_ifid = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cycles <= '0;
      flush_count  <= '0;
    end else begin
      if (!advance || lu)
        stall_cycles <= stall_cycles + PERF_W'(1);
      if (advance && ex_redirect)
        flush_count <= flush_count + PERF_W'(1);
    end
  end

endmodule
